// File: rtl/reset_seq_if.sv
// Handshake bundle between the reset sequencer and its controller:
// lock/req come in, the staged resets and status go out.
interface reset_seq_if #(
  parameter int N_OUT = 4
);
  logic             lock;
  logic             req;
  logic [N_OUT-1:0] rst_out;
  logic             done;
  logic [7:0]       restarts;

  modport master (output lock, req, input rst_out, done, restarts);
  modport slave  (input lock, req, output rst_out, done, restarts);
endinterface

// File: rtl/reset_seq.sv
// Staged power-on reset sequencer for the clk_tcxo domain: hold, wait for a
// stable lock, then release N_OUT resets bit 0 first with a fixed stagger.
module reset_seq #(
  parameter int N_OUT       = 4,
  parameter int CW          = 24,
  parameter int HOLD        = 16000000,
  parameter int LOCK_FILTER = 256,
  parameter int STAGGER     = 1000
) (
  input  logic       clk,
  input  logic       reset,
  reset_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD - 1);
  localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [N_OUT-1:0] rst_out_r;
  logic             done_r;
  logic [7:0]       restarts_r;

  logic lock_lost;
  logic restart;

  // Lock only matters once something has been released; req restarts from anywhere.
  assign lock_lost = !bus.lock && (state == S_RELEASE || state == S_RUN);
  assign restart   = bus.req || lock_lost;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_HOLD;
      cnt        <= '0;
      idx        <= '0;
      rst_out_r  <= '1;
      done_r     <= 1'b0;
      restarts_r <= '0;
    end else begin
      if (lock_lost && restarts_r != 8'hFF)
        restarts_r <= restarts_r + 8'd1;

      if (restart) begin
        state     <= S_HOLD;
        cnt       <= '0;
        idx       <= '0;
        rst_out_r <= '1;
        done_r    <= 1'b0;
      end else begin
        case (state)
          S_HOLD: begin
            if (cnt == HOLD_LAST) begin
              state <= S_WAIT_LOCK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end

          S_WAIT_LOCK: begin
            if (!bus.lock) begin
              cnt <= '0;
            end else if (cnt == FILTER_LAST) begin
              cnt       <= '0;
              idx       <= '0;
              rst_out_r <= rst_out_r << 1;
              if (N_OUT == 1) begin
                state  <= S_RUN;
                done_r <= 1'b1;
              end else begin
                state <= S_RELEASE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end

          // Shifting in zeros keeps the released outputs a contiguous low prefix.
          S_RELEASE: begin
            if (cnt == STAGGER_LAST) begin
              cnt       <= '0;
              idx       <= idx + IW'(1);
              rst_out_r <= rst_out_r << 1;
              if (int'(idx) == N_OUT - 2) begin
                state  <= S_RUN;
                done_r <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end

          S_RUN: begin
            rst_out_r <= '0;
            done_r    <= 1'b1;
          end

          default: begin
            state <= S_HOLD;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.rst_out  = rst_out_r;
  assign bus.done     = done_r;
  assign bus.restarts = restarts_r;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: a cycle model predicts every output
// after each edge, plus directed timing checks on the release edges.
module tb_reset_seq;

  localparam int N    = 3;
  localparam int CW   = 8;
  localparam int HOLD = 10;
  localparam int LF   = 5;
  localparam int ST   = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  reset_seq_if #(.N_OUT(N)) bus ();

  reset_seq #(
    .N_OUT      (N),
    .CW         (CW),
    .HOLD       (HOLD),
    .LOCK_FILTER(LF),
    .STAGGER    (ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [N-1:0] r;
    logic         d;
    logic [7:0]   c;
  } exp_t;

  exp_t q[$];

  int n_vec  = 0;
  int n_miss = 0;
  int ecnt   = 0;

  // Reference model: edges spent in hold, consecutive lock-high edges,
  // edges since the first release (-1 while nothing is released).
  int m_hold  = 0;
  int m_run   = 0;
  int m_since = -1;
  int m_rc    = 0;

  logic [N-1:0] hist[64];
  logic         dh[64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  task automatic model_hard_reset();
    m_hold  = 0;
    m_run   = 0;
    m_since = -1;
    m_rc    = 0;
    q.delete();
  endtask

  task automatic step(input logic l, input logic r);
    exp_t e;
    int   n;
    bus.lock = l;
    bus.req  = r;
    if (r || (!l && m_since >= 0)) begin
      if (!l && m_since >= 0 && m_rc < 255) m_rc++;
      m_hold  = 0;
      m_run   = 0;
      m_since = -1;
    end else if (m_hold < HOLD) begin
      m_hold++;
    end else if (m_since < 0) begin
      m_run = l ? m_run + 1 : 0;
      if (m_run == LF) m_since = 0;
    end else begin
      m_since++;
    end
    n = (m_since < 0) ? 0 : 1 + m_since / ST;
    if (n > N) n = N;
    e.r = {N{1'b1}} << n;
    e.d = (n == N);
    e.c = m_rc[7:0];
    q.push_back(e);

    @(posedge clk);
    #1;
    ecnt++;
    if (ecnt < 64) begin
      hist[ecnt] = bus.rst_out;
      dh[ecnt]   = bus.done;
    end
    e = q.pop_front();
    check("rst_out",  32'(bus.rst_out),  32'(e.r));
    check("done",     32'(bus.done),     32'(e.d));
    check("restarts", 32'(bus.restarts), 32'(e.c));
  endtask

  // Lock held high until rst_out reaches target; k = edges taken.
  task automatic run_lock(input int nmax, input logic [N-1:0] target, output int k);
    k = 0;
    while (bus.rst_out !== target && k < nmax) begin
      step(1'b1, 1'b0);
      k++;
    end
    if (bus.rst_out !== target) check("timeout", 32'(bus.rst_out), 32'(target));
  endtask

  initial begin
    int k;
    logic [7:0] rc0;

    bus.lock = 1'b1;
    bus.req  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rst_out",  32'(bus.rst_out),  32'(3'b111));
    check("rst_done",     32'(bus.done),     32'(1'b0));
    check("rst_restarts", 32'(bus.restarts), 32'(8'd0));
    @(negedge clk);
    reset = 1'b0;
    model_hard_reset();
    ecnt = 0;

    // Nominal sequence with lock high from reset release
    repeat (25) step(1'b1, 1'b0);
    check("nom_e14", 32'(hist[14]), 32'(3'b111));
    check("nom_e15", 32'(hist[15]), 32'(3'b110));
    check("nom_e18", 32'(hist[18]), 32'(3'b110));
    check("nom_e19", 32'(hist[19]), 32'(3'b100));
    check("nom_e22", 32'(hist[22]), 32'(3'b100));
    check("nom_e23", 32'(hist[23]), 32'(3'b000));
    check("nom_done22", 32'(dh[22]), 32'(1'b0));
    check("nom_done23", 32'(dh[23]), 32'(1'b1));
    check("nom_restarts", 32'(bus.restarts), 32'(8'd0));

    // req in RUN restarts without counting; then a one-cycle lock glitch in WAIT_LOCK
    step(1'b1, 1'b1);
    check("req_run_rst", 32'(bus.rst_out), 32'(3'b111));
    for (int i = 1; i <= 12; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    run_lock(20, 3'b110, k);
    check("glitch_rel_edge", 32'(13 + k), 32'(18));
    check("glitch_restarts", 32'(bus.restarts), 32'(8'd0));

    // Lock loss in RUN
    run_lock(40, 3'b000, k);
    step(1'b0, 1'b0);
    check("loss_rst_out",  32'(bus.rst_out),  32'(3'b111));
    check("loss_done",     32'(bus.done),     32'(1'b0));
    check("loss_restarts", 32'(bus.restarts), 32'(8'd1));
    run_lock(40, 3'b110, k);
    check("loss_rel_delay", 32'(k), 32'(15));

    // Lock loss and req together in RELEASE
    rc0 = bus.restarts;
    step(1'b0, 1'b1);
    check("both_rst_out",  32'(bus.rst_out),  32'(3'b111));
    check("both_restarts", 32'(bus.restarts), 32'(rc0 + 8'd1));
    step(1'b1, 1'b0);
    check("both_once", 32'(bus.restarts), 32'(rc0 + 8'd1));

    // req alone in RELEASE
    run_lock(40, 3'b110, k);
    rc0 = bus.restarts;
    step(1'b1, 1'b1);
    check("req_rel_rst_out",  32'(bus.rst_out),  32'(3'b111));
    check("req_rel_done",     32'(bus.done),     32'(1'b0));
    check("req_rel_restarts", 32'(bus.restarts), 32'(rc0));

    // Asynchronous reset between edges mid-RELEASE
    run_lock(40, 3'b110, k);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out",  32'(bus.rst_out),  32'(3'b111));
    check("async_done",     32'(bus.done),     32'(1'b0));
    check("async_restarts", 32'(bus.restarts), 32'(8'd0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_hard_reset();
    ecnt = 0;

    // Saturation of the restart counter
    for (int i = 0; i < 256; i++) begin
      run_lock(40, 3'b000, k);
      step(1'b0, 1'b0);
    end
    check("sat_restarts", 32'(bus.restarts), 32'(8'd255));
    run_lock(40, 3'b000, k);
    check("sat_done", 32'(bus.done), 32'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
